// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over windows of 2^N enabled
// samples and presents each saturated N-bit count through a valid/ready
// handshake, with a sticky flag for results overwritten before consumption.
module bitstream_decoder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         x,
  input  logic         clear,
  output logic [N-1:0] y,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         overrun
);

  // The ones counter needs one extra bit so that an all-ones window (2^N) is representable.
  localparam int unsigned CW = N + 1;

  logic [N-1:0]  idx_q, idx_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [N-1:0]  y_q, y_d;
  logic          y_valid_q, y_valid_d;
  logic          overrun_q, overrun_d;

  logic          last_c;
  logic          xfer_c;
  logic [CW-1:0] final_c;
  logic [N-1:0]  sat_c;

  // Window bookkeeping: final-sample detect, closing count and its saturation.
  always_comb begin
    last_c  = (idx_q == {N{1'b1}});
    xfer_c  = y_valid_q & y_ready;
    final_c = ones_q + CW'(x);
    sat_c   = final_c[N] ? {N{1'b1}} : final_c[N-1:0];
  end

  // Next state: clear dominates; otherwise handshake, then sampling/completion.
  always_comb begin
    idx_d     = idx_q;
    ones_d    = ones_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    overrun_d = overrun_q;

    if (clear) begin
      idx_d     = '0;
      ones_d    = '0;
      y_d       = '0;
      y_valid_d = 1'b0;
      overrun_d = 1'b0;
    end else begin
      // A transfer retires the current result; a completion below may re-arm it.
      if (xfer_c) begin
        y_valid_d = 1'b0;
      end
      if (en) begin
        if (last_c) begin
          idx_d     = '0;
          ones_d    = '0;
          y_d       = sat_c;
          y_valid_d = 1'b1;
          // Overwriting a pending result that is not being accepted is an overrun.
          if (y_valid_q && !y_ready) begin
            overrun_d = 1'b1;
          end
        end else begin
          idx_d  = idx_q + N'(1);
          ones_d = final_c;
        end
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      ones_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      ones_q    <= ones_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Self-checking bench for bitstream_decoder (N=8 main instance, N=2 for edge coincidence).
module tb_bitstream_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, x = 1'b0, clear = 1'b0, y_ready = 1'b0;
  logic [7:0] y;
  logic       y_valid, overrun;

  logic       en2 = 1'b0, x2 = 1'b0, clr2 = 1'b0, rdy2 = 1'b0;
  logic [1:0] y2;
  logic       y2_valid, overrun2;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int exp_v;

  always #5 clk = ~clk;

  bitstream_decoder #(.N(8)) dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .clear(clear),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .overrun(overrun)
  );

  bitstream_decoder #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .x(x2), .clear(clr2),
    .y(y2), .y_valid(y2_valid), .y_ready(rdy2), .overrun(overrun2)
  );

  // Scoreboard: every accepted result on the N=8 instance is checked against the queue.
  always @(negedge clk) begin
    if (!rst && y_valid === 1'b1 && y_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected: got y=%0d, expected no transfer", y);
      end else begin
        exp_v = exp_q.pop_front();
        if (y !== 8'(exp_v)) begin
          failures++;
          $display("FAIL scoreboard_y: got %0d, expected %0d", y, exp_v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present `total` enabled samples, the first `n_ones` of them ones.
  task automatic feed(input int n_ones, input int total);
    for (int i = 0; i < total; i++) begin
      en = 1'b1;
      x  = (i < n_ones);
      tick();
    end
    en = 1'b0;
    x  = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (y !== 8'd0 || y_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got y=%0d v=%0b o=%0b, expected 0/0/0", y, y_valid, overrun);
    end
    checks++;
    if (y2 !== 2'd0 || y2_valid !== 1'b0 || overrun2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs_n2: got y=%0d v=%0b o=%0b, expected 0/0/0", y2, y2_valid, overrun2);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_zeros();
    y_ready = 1'b1;
    exp_q.push_back(0);
    feed(0, 255);
    checks++;
    if (y_valid !== 1'b0) begin
      failures++;
      $display("FAIL zeros_early_valid: got %0b, expected 0", y_valid);
    end
    feed(0, 1);
    checks++;
    if (y_valid !== 1'b1 || y !== 8'd0) begin
      failures++;
      $display("FAIL zeros_result: got v=%0b y=%0d, expected v=1 y=0", y_valid, y);
    end
    tick();
    checks++;
    if (y_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL zeros_pulse: got v=%0b o=%0b, expected 0/0", y_valid, overrun);
    end
  endtask

  task automatic test_saturate();
    y_ready = 1'b1;
    exp_q.push_back(255);
    feed(256, 256);
    checks++;
    if (y_valid !== 1'b1 || y !== 8'd255) begin
      failures++;
      $display("FAIL sat_256: got v=%0b y=%0d, expected v=1 y=255", y_valid, y);
    end
    exp_q.push_back(255);
    feed(255, 256);
    checks++;
    if (y !== 8'd255) begin
      failures++;
      $display("FAIL sat_255: got %0d, expected 255", y);
    end
    exp_q.push_back(128);
    feed(128, 256);
    checks++;
    if (y !== 8'd128) begin
      failures++;
      $display("FAIL half_128: got %0d, expected 128", y);
    end
    tick();
  endtask

  task automatic test_en_toggle();
    int  rises = 0;
    int  first_i = -1;
    logic prev_v = 1'b0;
    y_ready = 1'b1;
    exp_q.push_back(64);
    exp_q.push_back(64);
    for (int i = 0; i < 1024; i++) begin
      en = (i % 2 == 0);
      x  = (i % 2 == 0) && (((i / 2) % 4) == 0);
      tick();
      if (y_valid === 1'b1 && !prev_v) begin
        rises++;
        if (first_i < 0) first_i = i;
      end
      prev_v = y_valid;
    end
    en = 1'b0;
    x  = 1'b0;
    tick();
    checks++;
    if (first_i != 510) begin
      failures++;
      $display("FAIL toggle_latency: first valid after clock %0d, expected 510", first_i);
    end
    checks++;
    if (rises != 2) begin
      failures++;
      $display("FAIL toggle_windows: got %0d results, expected 2", rises);
    end
  endtask

  task automatic test_overrun();
    y_ready = 1'b0;
    feed(64, 256);
    checks++;
    if (y !== 8'd64 || y_valid !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_win1: got y=%0d v=%0b o=%0b, expected 64/1/0", y, y_valid, overrun);
    end
    feed(100, 100);
    checks++;
    if (y !== 8'd64 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovr_hold: got y=%0d v=%0b, expected 64/1", y, y_valid);
    end
    feed(92, 156);
    checks++;
    if (y !== 8'd192 || y_valid !== 1'b1 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_win2: got y=%0d v=%0b o=%0b, expected 192/1/1", y, y_valid, overrun);
    end
    exp_q.push_back(192);
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    checks++;
    if (y_valid !== 1'b0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_accept: got v=%0b o=%0b, expected 0/1", y_valid, overrun);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (y !== 8'd0 || y_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear: got y=%0d v=%0b o=%0b, expected 0/0/0", y, y_valid, overrun);
    end
  endtask

  task automatic test_coincide();
    rdy2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en2 = 1'b1;
      x2  = (i < 3);
      tick();
    end
    checks++;
    if (y2 !== 2'd3 || y2_valid !== 1'b1) begin
      failures++;
      $display("FAIL coin_win1: got y=%0d v=%0b, expected 3/1", y2, y2_valid);
    end
    for (int i = 0; i < 4; i++) begin
      x2   = (i == 0);
      rdy2 = (i == 3);
      tick();
      if (i == 2) begin
        checks++;
        if (y2 !== 2'd3) begin
          failures++;
          $display("FAIL coin_hold: got %0d, expected 3", y2);
        end
      end
    end
    en2 = 1'b0;
    x2  = 1'b0;
    checks++;
    if (y2 !== 2'd1 || y2_valid !== 1'b1 || overrun2 !== 1'b0) begin
      failures++;
      $display("FAIL coin_result: got y=%0d v=%0b o=%0b, expected 1/1/0", y2, y2_valid, overrun2);
    end
    tick();
    rdy2 = 1'b0;
    checks++;
    if (y2_valid !== 1'b0) begin
      failures++;
      $display("FAIL coin_accept: got v=%0b, expected 0", y2_valid);
    end
  endtask

  task automatic test_async_rst();
    y_ready = 1'b0;
    feed(10, 256);
    feed(100, 100);
    checks++;
    if (y_valid !== 1'b1 || y !== 8'd10) begin
      failures++;
      $display("FAIL arst_pre: got y=%0d v=%0b, expected 10/1", y, y_valid);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (y !== 8'd0 || y_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate: got y=%0d v=%0b o=%0b, expected 0/0/0", y, y_valid, overrun);
    end
    tick();
    rst = 1'b0;
    y_ready = 1'b1;
    exp_q.push_back(255);
    feed(256, 256);
    checks++;
    if (y !== 8'd255 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_after: got y=%0d v=%0b, expected 255/1", y, y_valid);
    end
    tick();
    feed(50, 50);
    clear = 1'b1;
    en = 1'b1;
    x = 1'b1;
    tick();
    clear = 1'b0;
    en = 1'b0;
    exp_q.push_back(255);
    feed(256, 256);
    checks++;
    if (y !== 8'd255 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_after: got y=%0d v=%0b, expected 255/1", y, y_valid);
    end
    tick();
    y_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_saturate();
    test_en_toggle();
    test_overrun();
    test_coincide();
    test_async_rst();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
